// File: rtl/pec_pair_sched_pkg.sv
// -----------------------------------------------------------------------------
// pec_pkg
// Shared types and default sizes for the sparse-pair scheduler of a PE MAC
// lane.
//   - stateT        : scheduler state (IDLE / ISSUE)
//   - *_DEF         : default flag-word, offset-index and buffer-address widths
//   - OFF_WIDTH_DEF : width of a masked popcount; one bit wider than the
//                     position index so a full word of set flags still fits
// -----------------------------------------------------------------------------
package pec_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int ADDR_WIDTH_DEF = 5;
   localparam int BASE_WIDTH_DEF = 12;
   localparam int OFF_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } stateT;

endpackage : pec_pkg

// File: rtl/pec_pair_sched_pair_pick.sv
// -----------------------------------------------------------------------------
// pec_pair_pick
// Combinational pair selector. Finds the lowest set bit of the remaining match
// vector and counts the activation / weight nonzero flags strictly below it,
// which gives each operand's offset into its compressed buffer.
//
// Ports
//   act, wei   in  DATA_WIDTH  latched nonzero flags of the word
//   match      in  DATA_WIDTH  match bits not yet issued
//   pos        out ADDR_WIDTH  index of the lowest remaining match bit
//   act_off    out OFF_WIDTH   popcount(act below pos)
//   wei_off    out OFF_WIDTH   popcount(wei below pos)
//   one_left   out 1           exactly one match bit remains
// When match is zero, pos and the offsets are don't-care.
// -----------------------------------------------------------------------------
module pec_pair_pick
   import pec_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic [DATA_WIDTH-1:0] act,
   input  logic [DATA_WIDTH-1:0] wei,
   input  logic [DATA_WIDTH-1:0] match,
   output logic [ADDR_WIDTH-1:0] pos,
   output logic [ADDR_WIDTH:0]   act_off,
   output logic [ADDR_WIDTH:0]   wei_off,
   output logic                  one_left
);

   localparam int OFF_WIDTH = ADDR_WIDTH + 1;
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] lowBit;
   logic [DATA_WIDTH-1:0] belowMask;
   logic [DATA_WIDTH-1:0] actMasked;
   logic [DATA_WIDTH-1:0] weiMasked;

   // Two's-complement trick isolates the lowest set bit; subtracting one then
   // yields a mask of every position strictly below it.
   assign lowBit    = match & (~match + ONE);
   assign belowMask = lowBit - ONE;

   // Clearing the lowest bit leaves nothing exactly when one bit remains.
   assign one_left  = (match != '0) && ((match & (match - ONE)) == '0);

   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : gMask
         assign actMasked[gi] = act[gi] & belowMask[gi];
         assign weiMasked[gi] = wei[gi] & belowMask[gi];
      end
   endgenerate

   // Priority encoder: scanning downward, the last hit is the lowest bit.
   always_comb begin
      pos = '0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         if (match[i]) begin
            pos = ADDR_WIDTH'(i);
         end
      end
   end

   always_comb begin
      act_off = '0;
      wei_off = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         act_off = act_off + OFF_WIDTH'(actMasked[i]);
         wei_off = wei_off + OFF_WIDTH'(weiMasked[i]);
      end
   end

endmodule : pec_pair_pick

// File: rtl/pec_pair_sched.sv
// -----------------------------------------------------------------------------
// pec_pair_sched
// Sparse-pair scheduler for one PE MAC lane. Accepts an activation/weight
// nonzero-flag word with compressed-buffer bases, then issues one matched
// (act, wei) pair per cycle with the buffer read address of each operand:
// base + popcount(flags below the match position), wrapping modulo
// 2^BASE_WIDTH.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   flg_vld/flg_rdy             flag-word handshake (flg_rdy combinational)
//   flg_act, flg_wei            nonzero flags of the word
//   flg_last                    word closes the accumulation group
//   act_base, wei_base          buffer address of each operand's first nonzero
//   mac_vld/mac_rdy             pair handshake towards the MAC
//   act_addr, wei_addr          operand read addresses
//   mac_first, mac_last         first / last pair of the word
//   mac_grp_last                last pair of a group-closing word
//   word_done, word_empty       one-cycle retire pulse; empty = no matches
//   busy                        scheduler not idle
// -----------------------------------------------------------------------------
module pec_pair_sched
   import pec_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int BASE_WIDTH = BASE_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flg_vld,
   output logic                  flg_rdy,
   input  logic [DATA_WIDTH-1:0] flg_act,
   input  logic [DATA_WIDTH-1:0] flg_wei,
   input  logic                  flg_last,
   input  logic [BASE_WIDTH-1:0] act_base,
   input  logic [BASE_WIDTH-1:0] wei_base,
   output logic                  mac_vld,
   input  logic                  mac_rdy,
   output logic [BASE_WIDTH-1:0] act_addr,
   output logic [BASE_WIDTH-1:0] wei_addr,
   output logic                  mac_first,
   output logic                  mac_last,
   output logic                  mac_grp_last,
   output logic                  word_done,
   output logic                  word_empty,
   output logic                  busy
);

   localparam int OFF_WIDTH = ADDR_WIDTH + 1;
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   // Scheduler state and latched word
   stateT                 stateReg, stateNext;
   logic [DATA_WIDTH-1:0] actReg, weiReg, matchReg;
   logic [BASE_WIDTH-1:0] actBaseReg, weiBaseReg;
   logic                  grpLastReg;
   logic [ADDR_WIDTH-1:0] posReg;

   // Registered MAC-side outputs
   logic                  macVldReg, macFirstReg, macLastReg, macGrpLastReg;
   logic [BASE_WIDTH-1:0] actAddrReg, weiAddrReg;
   logic                  wordDoneReg, wordEmptyReg;

   // Source of the next presented pair: either a freshly accepted word or the
   // current word with the just-issued bit removed.
   logic [DATA_WIDTH-1:0] srcAct, srcWei, srcMatch;
   logic [BASE_WIDTH-1:0] srcActBase, srcWeiBase;
   logic                  srcGrpLast;

   logic [ADDR_WIDTH-1:0] pickPos;
   logic [OFF_WIDTH-1:0]  pickActOff, pickWeiOff;
   logic                  pickOneLeft;

   logic                  macFire, retire, loadFire, loadEmpty, update;
   logic [DATA_WIDTH-1:0] loadMatch;

   assign macFire   = macVldReg & mac_rdy;
   assign retire    = macFire & macLastReg;
   // Reset holds the flag FIFO off; the ready term itself follows the state.
   assign flg_rdy   = ~rst & ((stateReg == IDLE) | retire);
   assign loadFire  = flg_vld & flg_rdy;
   assign loadMatch = flg_act & flg_wei;
   assign loadEmpty = (loadMatch == '0);
   assign update    = loadFire | macFire;

   always_comb begin
      srcAct     = actReg;
      srcWei     = weiReg;
      srcMatch   = matchReg;
      srcActBase = actBaseReg;
      srcWeiBase = weiBaseReg;
      srcGrpLast = grpLastReg;
      if (loadFire) begin
         srcAct     = flg_act;
         srcWei     = flg_wei;
         srcMatch   = loadMatch;
         srcActBase = act_base;
         srcWeiBase = wei_base;
         srcGrpLast = flg_last;
      end else if (macFire) begin
         srcMatch = matchReg & ~(ONE << posReg);
      end
   end

   pec_pair_pick #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) uPick (
      .act      (srcAct),
      .wei      (srcWei),
      .match    (srcMatch),
      .pos      (pickPos),
      .act_off  (pickActOff),
      .wei_off  (pickWeiOff),
      .one_left (pickOneLeft)
   );

   always_comb begin
      stateNext = stateReg;
      if (update) begin
         stateNext = (srcMatch != '0) ? ISSUE : IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateReg      <= IDLE;
         actReg        <= '0;
         weiReg        <= '0;
         matchReg      <= '0;
         actBaseReg    <= '0;
         weiBaseReg    <= '0;
         grpLastReg    <= 1'b0;
         posReg        <= '0;
         macVldReg     <= 1'b0;
         macFirstReg   <= 1'b0;
         macLastReg    <= 1'b0;
         macGrpLastReg <= 1'b0;
         actAddrReg    <= '0;
         weiAddrReg    <= '0;
         wordDoneReg   <= 1'b0;
         wordEmptyReg  <= 1'b0;
      end else begin
         stateReg <= stateNext;
         // A word retires on its last handshake or when it arrives empty. If
         // an empty word is accepted on another word's last handshake, both
         // retire together under a single non-empty pulse.
         wordDoneReg  <= retire | (loadFire & loadEmpty);
         wordEmptyReg <= loadFire & loadEmpty & ~retire;
         // Without a handshake or a load every pair output holds, which keeps
         // them stable under MAC backpressure.
         if (update) begin
            actReg        <= srcAct;
            weiReg        <= srcWei;
            matchReg      <= srcMatch;
            actBaseReg    <= srcActBase;
            weiBaseReg    <= srcWeiBase;
            grpLastReg    <= srcGrpLast;
            posReg        <= pickPos;
            macVldReg     <= (srcMatch != '0);
            macFirstReg   <= loadFire & (srcMatch != '0);
            macLastReg    <= pickOneLeft;
            macGrpLastReg <= pickOneLeft & srcGrpLast;
            actAddrReg    <= srcActBase + BASE_WIDTH'(pickActOff);
            weiAddrReg    <= srcWeiBase + BASE_WIDTH'(pickWeiOff);
         end
      end
   end

   assign mac_vld      = macVldReg;
   assign mac_first    = macFirstReg;
   assign mac_last     = macLastReg;
   assign mac_grp_last = macGrpLastReg;
   assign act_addr     = actAddrReg;
   assign wei_addr     = weiAddrReg;
   assign word_done    = wordDoneReg;
   assign word_empty   = wordEmptyReg;
   assign busy         = (stateReg != IDLE);

endmodule : pec_pair_sched

// File: tb/tb_pec_pair_sched.sv
// -----------------------------------------------------------------------------
// tb_pec_pair_sched
// Directed and randomized stimulus for pec_pair_sched. A reference model turns
// each accepted flag word into its list of expected pairs and retire pulses;
// a negedge monitor compares every presented pair and every word_done.
// -----------------------------------------------------------------------------
module tb_pec_pair_sched;

   typedef struct packed {
      logic [11:0] a;
      logic [11:0] w;
      logic        f;
      logic        l;
      logic        g;
   } pairT;

   logic        clk = 1'b0;
   logic        rst;
   logic        flg_vld, flg_rdy, flg_last;
   logic [31:0] flg_act, flg_wei;
   logic [11:0] act_base, wei_base;
   logic        mac_vld, mac_rdy, mac_first, mac_last, mac_grp_last;
   logic [11:0] act_addr, wei_addr;
   logic        word_done, word_empty, busy;

   pairT pairQ[$];
   bit   doneQ[$];
   int   total = 0;
   int   bad   = 0;
   bit   accSeen = 1'b0;
   bit   prevStall = 1'b0;
   pairT prevOut;

   always #5 clk = ~clk;

   pec_pair_sched dut (
      .clk          (clk),
      .rst          (rst),
      .flg_vld      (flg_vld),
      .flg_rdy      (flg_rdy),
      .flg_act      (flg_act),
      .flg_wei      (flg_wei),
      .flg_last     (flg_last),
      .act_base     (act_base),
      .wei_base     (wei_base),
      .mac_vld      (mac_vld),
      .mac_rdy      (mac_rdy),
      .act_addr     (act_addr),
      .wei_addr     (wei_addr),
      .mac_first    (mac_first),
      .mac_last     (mac_last),
      .mac_grp_last (mac_grp_last),
      .word_done    (word_done),
      .word_empty   (word_empty),
      .busy         (busy)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: walk the flag positions in order; each common nonzero
   // yields one pair whose offsets are plain counts of earlier nonzeros.
   task automatic modelWord(input logic [31:0] a, input logic [31:0] w,
                            input logic [11:0] ab, input logic [11:0] wb, input logic gl);
      int n = 0;
      int k = 0;
      for (int i = 0; i < 32; i++) if (a[i] && w[i]) n++;
      for (int i = 0; i < 32; i++) begin
         if (a[i] && w[i]) begin
            int offA = 0;
            int offW = 0;
            pairT p;
            for (int j = 0; j < i; j++) begin
               offA += int'(a[j]);
               offW += int'(w[j]);
            end
            p.a = 12'((int'(ab) + offA) % 4096);
            p.w = 12'((int'(wb) + offW) % 4096);
            p.f = (k == 0);
            p.l = (k == n - 1);
            p.g = (k == n - 1) && gl;
            pairQ.push_back(p);
            k++;
         end
      end
   endtask

   // Monitor / scoreboard: samples on the falling edge, away from the active
   // edge; handshakes seen here complete on the following rising edge.
   always @(negedge clk) begin
      pairT cur;
      bit   retireNow;
      cur       = {act_addr, wei_addr, mac_first, mac_last, mac_grp_last};
      retireNow = 1'b0;
      if (rst) begin
         prevStall = 1'b0;
         accSeen   = 1'b0;
      end else begin
         if (mac_vld) begin
            if (pairQ.size() == 0) begin
               chk("vld_unexpected", {31'b0, mac_vld}, 32'd0);
            end else begin
               chk("pair", 32'(cur), 32'(pairQ[0]));
               if (mac_rdy) begin
                  retireNow = pairQ[0].l;
                  void'(pairQ.pop_front());
               end
            end
         end
         if (prevStall) chk("stall_hold", {4'b0, mac_vld, cur}, {4'b0, 1'b1, prevOut});
         prevStall = mac_vld && !mac_rdy;
         prevOut   = cur;
         if (word_done) begin
            if (doneQ.size() == 0) chk("done_unexpected", {31'b0, word_done}, 32'd0);
            else chk("done_empty", {31'b0, word_empty}, {31'b0, doneQ.pop_front()});
         end else if (word_empty) begin
            chk("empty_no_done", {31'b0, word_empty}, 32'd0);
         end
         accSeen = flg_vld && flg_rdy;
         if (accSeen) begin
            if ((flg_act & flg_wei) == 32'd0) begin
               if (!retireNow) doneQ.push_back(1'b1);
            end else begin
               modelWord(flg_act, flg_wei, act_base, wei_base, flg_last);
            end
         end
         if (retireNow) doneQ.push_back(1'b0);
      end
   end

   // Drives a word from just after a rising edge; returns just after the
   // rising edge on which it was accepted.
   task automatic sendWord(input logic [31:0] a, input logic [31:0] w,
                           input logic [11:0] ab, input logic [11:0] wb, input logic gl);
      flg_act  = a;
      flg_wei  = w;
      act_base = ab;
      wei_base = wb;
      flg_last = gl;
      flg_vld  = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (flg_rdy) begin
            @(posedge clk);
            #1;
            flg_vld = 1'b0;
            return;
         end
      end
      chk("accept_timeout", {31'b0, flg_rdy}, 32'd1);
      flg_vld = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b1;
      flg_vld  = 1'b0;
      flg_act  = '0;
      flg_wei  = '0;
      flg_last = 1'b0;
      act_base = '0;
      wei_base = '0;
      mac_rdy  = 1'b1;

      // Reset state
      tick(2);
      chk("rst_mac_vld", {31'b0, mac_vld}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, word_done}, 32'd0);
      chk("rst_flg_rdy", {31'b0, flg_rdy}, 32'd0);
      chk("rst_addr", {8'b0, act_addr, wei_addr}, 32'd0);
      #1 rst = 1'b0;
      #1;
      chk("rel_flg_rdy", {31'b0, flg_rdy}, 32'd1);
      tick(1);

      // Two matches, first-cycle latency and retire pulse timing
      sendWord(32'h0000_00F0, 32'h0000_0030, 12'd100, 12'd200, 1'b0);
      @(negedge clk);
      chk("t1_p1", {mac_vld, mac_first, act_addr, wei_addr}, {1'b1, 1'b1, 12'd100, 12'd200});
      @(negedge clk);
      chk("t1_p2", {mac_vld, mac_last, act_addr, wei_addr}, {1'b1, 1'b1, 12'd101, 12'd201});
      @(negedge clk);
      chk("t1_done", {mac_vld, word_done, word_empty}, 3'b010);
      tick(1);

      // Widest offset and group-last flag
      sendWord(32'hFFFF_FFFF, 32'h8000_0001, 12'd0, 12'd0, 1'b1);
      @(negedge clk);
      chk("t2_p1", {mac_first, mac_grp_last, act_addr, wei_addr}, {1'b1, 1'b0, 12'd0, 12'd0});
      @(negedge clk);
      chk("t2_p2", {mac_last, mac_grp_last, act_addr, wei_addr}, {1'b1, 1'b1, 12'd31, 12'd1});
      tick(2);

      // Empty word
      sendWord(32'h0000_000F, 32'h0000_00F0, 12'd5, 12'd5, 1'b1);
      @(negedge clk);
      chk("t3_empty", {mac_vld, word_done, word_empty, flg_rdy, mac_grp_last}, 5'b01110);
      tick(2);

      // Three matches with a three-cycle stall on the second pair
      begin
         int cnt = 0;
         int dones = 0;
         sendWord(32'h0000_0007, 32'h0000_0007, 12'd40, 12'd80, 1'b0);
         for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (mac_vld) cnt++;
            if (word_done) begin
               dones++;
               break;
            end
            @(posedge clk);
            #1;
            mac_rdy = !(cnt >= 1 && cnt <= 3);
         end
         chk("t4_cycles", 32'(cnt), 32'd6);
         chk("t4_done", 32'(dones), 32'd1);
         mac_rdy = 1'b1;
      end
      tick(2);

      // Back-to-back words with no bubble
      fork
         begin
            sendWord(32'h0000_0003, 32'h0000_0003, 12'd10, 12'd20, 1'b0);
            sendWord(32'h0000_0005, 32'h0000_0005, 12'd30, 12'd40, 1'b1);
         end
         begin
            int run = 0;
            int t = 0;
            @(negedge clk);
            while (!mac_vld && t < 20) begin
               @(negedge clk);
               t++;
            end
            while (mac_vld && run < 10) begin
               run++;
               if (run == 2) chk("t5_w1_last", {31'b0, mac_last}, 32'd1);
               if (run == 3) chk("t5_w2_first", {19'b0, mac_first, act_addr}, {19'b0, 1'b1, 12'd30});
               @(negedge clk);
            end
            chk("t5_run", 32'(run), 32'd4);
         end
      join
      tick(2);

      // Reset in the middle of a four-match word
      sendWord(32'h0000_000F, 32'h0000_000F, 12'd50, 12'd60, 1'b0);
      @(negedge clk);
      tick(1);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      pairQ.delete();
      doneQ.delete();
      #1;
      chk("t6_rst_vld_busy", {mac_vld, busy}, 2'b00);
      @(negedge clk);
      chk("t6_rst_done", {31'b0, word_done}, 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t6_rel_rdy", {31'b0, flg_rdy}, 32'd1);
      sendWord(32'h0000_0003, 32'h0000_0002, 12'd7, 12'd9, 1'b0);
      @(negedge clk);
      chk("t6_next", {mac_vld, mac_first, mac_last, act_addr, wei_addr}, {1'b1, 1'b1, 1'b1, 12'd8, 12'd9});
      tick(3);

      // Randomized traffic with random backpressure
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk);
         #1;
         mac_rdy = ($urandom_range(0, 3) != 0);
         if (!flg_vld || accSeen) begin
            if ($urandom_range(0, 2) != 0) begin
               int mode = $urandom_range(0, 3);
               flg_act = $urandom;
               case (mode)
                  0:       flg_wei = $urandom & $urandom;
                  1:       flg_wei = $urandom;
                  2:       flg_wei = ~flg_act;
                  default: flg_wei = 32'h1 << $urandom_range(0, 31);
               endcase
               act_base = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(4070, 4095)) : 12'($urandom);
               wei_base = 12'($urandom);
               flg_last = 1'($urandom_range(0, 1));
               flg_vld  = 1'b1;
            end else begin
               flg_vld = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
      flg_vld = 1'b0;
      mac_rdy = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (pairQ.size() == 0 && doneQ.size() == 0) break;
      end
      chk("drain", 32'(pairQ.size() + doneQ.size()), 32'd0);
      @(negedge clk);
      chk("final_idle", {30'b0, mac_vld, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pec_pair_sched

// File: doc/pec_pair_sched.md
# pec_pair_sched

Sparse-pair scheduler for one PE MAC lane. It accepts a pair of activation/weight nonzero-flag words with their compressed-buffer base addresses. It then issues one matched (act, wei) pair per cycle to the MAC, with the compressed-buffer addresses of both operands. Each address is the base plus the popcount of that operand's flags below the match position. It sits between the flag FIFO and the act/wei SRAM read ports, and sequences the flag-intersection/offset datapath.

## Interface
- DATA_WIDTH, 32, flag bits per word (channel depth).
- ADDR_WIDTH, 5, log2(DATA_WIDTH); offsets are ADDR_WIDTH+1 bits.
- BASE_WIDTH, 12, compressed-buffer address width.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flg_vld  in  1  flag word valid.
- flg_rdy  out  1  flag word accepted when flg_vld&flg_rdy.
- flg_act  in  DATA_WIDTH  activation nonzero flags.
- flg_wei  in  DATA_WIDTH  weight nonzero flags.
- flg_last  in  1  last word of the accumulation group.
- act_base  in  BASE_WIDTH  activation buffer address of bit-0 nonzero.
- wei_base  in  BASE_WIDTH  weight buffer address of bit-0 nonzero.
- mac_vld  out  1  pair valid.
- mac_rdy  in  1  MAC accepts pair.
- act_addr  out  BASE_WIDTH  activation read address.
- wei_addr  out  BASE_WIDTH  weight read address.
- mac_first  out  1  first pair of the word.
- mac_last  out  1  last pair of the word.
- mac_grp_last  out  1  mac_last & latched flg_last.
- word_done  out  1  one-cycle pulse per word retired.
- word_empty  out  1  qualifies word_done: the word had no matches.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE.
- In IDLE, flg_rdy=1. On accept, latch act, wei, bases and flg_last. Set match = flg_act & flg_wei.
- If match==0, stay IDLE. Pulse word_done=1 and word_empty=1 next cycle. Group_last still applies: mac_grp_last is not asserted. The empty-word pulse is the group terminator.
- If match!=0, go to ISSUE. pos = lowest set bit of match.
- act_addr = act_base + popcount(act & ((1<<pos)-1)); wei_addr likewise. Addition wraps modulo 2^BASE_WIDTH.
- mac_first=1 on the first pair after load. mac_last=1 when exactly one match bit remains.
- On mac_vld&mac_rdy, clear bit pos in match and present the next pair in the following cycle.
- On the handshake with mac_last, do one of two things:
  - If flg_vld, accept the next word in the same cycle. flg_rdy = IDLE | (mac_vld&mac_rdy&mac_last), combinational from mac_rdy. Then reload and stay in ISSUE, or go to IDLE if the new match is 0.
  - Otherwise, go to IDLE.
  - In both cases, pulse word_done (word_empty=0) the next cycle.
- Reset values: mac_vld, flg_rdy (as a register term), word_done, word_empty, mac_first, mac_last, mac_grp_last, busy = 0. act_addr, wei_addr, latched flags and match = 0. State = IDLE. flg_rdy output = 1 once rst deasserts.

## Timing
- Accept at cycle N gives the first mac_vld at N+1. All mac_* outputs are registered.
- Throughput is one pair/cycle with mac_rdy=1. A word with k matches occupies k cycles. There is no bubble between back-to-back words.
- Backpressure: while mac_vld&!mac_rdy, every mac_* output holds stable.
- word_done comes one cycle after the retiring handshake, or after accepting an empty word. It never coincides with a reset.
- rst mid-ISSUE: the current word is discarded and mac_vld drops asynchronously. No word_done is issued for the discarded word.
- pos=DATA_WIDTH-1 with all lower flags set: offset = DATA_WIDTH-1, which needs ADDR_WIDTH bits. The offset carries ADDR_WIDTH+1 bits before zero-extension to BASE_WIDTH.

## Structure
- Shared package pec_pkg:
  - state enum {IDLE, ISSUE};
  - DATA_WIDTH/ADDR_WIDTH/BASE_WIDTH defaults;
  - offset width constant.
- Combinational sub-module pec_pair_pick:
  - inputs: act, wei, match;
  - outputs: pos, act_off, wei_off, one_left.
  - It is a lowest-set-bit priority encoder plus two masked popcounts.
- The top holds the FSM, the latched word, the match register and the output registers.

## Test plan
- act=0x000000F0, wei=0x00000030, bases 100/200, mac_rdy=1 -> N+1: (100,200) with first=1; N+2: (101,201) with last=1; word_done=1, word_empty=0 at N+3.
- act=0xFFFFFFFF, wei=0x80000001, bases 0/0 -> (0,0) first, then (31,1) last. mac_grp_last=1 when flg_last=1.
- act=0x0000000F, wei=0x000000F0 -> mac_vld never asserts; word_done=1 and word_empty=1 at N+1; flg_rdy stays 1.
- 3-match word with mac_rdy low for 3 cycles on the second pair -> that pair holds its addresses and flags stable; total 6 cycles; exactly one word_done.
- Two words queued (flg_vld=1), mac_rdy=1 -> second word accepted on first word's last handshake; mac_vld continuous; first flag of word 2 directly follows last of word 1.
- rst asserted in the middle of a 4-match word -> mac_vld=0 and busy=0 immediately; no word_done; flg_rdy=1 after release; next word issues from its own bases.
